// File: rtl/tdm_pkg.sv
// Shared definitions for the 4-slot TDM link (serializer and deserializer sides).
package tdm_pkg;

    localparam int unsigned TDM_SLOTS = 4;
    localparam int unsigned SLOT_W    = $clog2(TDM_SLOTS);

    typedef logic [SLOT_W-1:0] slot_t;

    typedef enum logic [1:0] {
        HUNT,
        ASSEMBLE,
        STALL
    } tdm_state_e;

    localparam slot_t LAST_SLOT = slot_t'(TDM_SLOTS - 1);

endpackage

// File: rtl/tdm_demux_4ch.sv
// TDM deserializer: reassembles 4-slot frames from a beat stream into parallel
// channel words, with one frame of assembly buffering behind the output register.
module tdm_demux_4ch
    import tdm_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sof,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_ch0,
    output logic [WIDTH-1:0] out_ch1,
    output logic [WIDTH-1:0] out_ch2,
    output logic [WIDTH-1:0] out_ch3,
    output logic             sync_err
);

    tdm_state_e       state_q, state_d;
    slot_t            cnt_q, cnt_d;
    logic [WIDTH-1:0] asm_q [TDM_SLOTS];
    logic [WIDTH-1:0] asm_d [TDM_SLOTS];
    logic [WIDTH-1:0] out_q [TDM_SLOTS];
    logic [WIDTH-1:0] out_d [TDM_SLOTS];
    logic             out_valid_q, out_valid_d;
    logic             sync_err_q, sync_err_d;

    logic accept;
    logic take;

    // Ready depends on state only, so there is no combinational path from out_ready.
    assign in_ready = (state_q != STALL);
    assign accept   = in_valid && in_ready;
    assign take     = out_valid_q && out_ready;

    // Next-state, assembly, output-register and sync-error logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        asm_d       = asm_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        sync_err_d  = 1'b0;

        if (take) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            HUNT: begin
                if (accept && in_sof) begin
                    asm_d[0] = in_data;
                    cnt_d    = slot_t'(1);
                    state_d  = ASSEMBLE;
                end
            end

            ASSEMBLE: begin
                if (accept) begin
                    if (in_sof) begin
                        // Mid-frame sof: restart the frame from this beat.
                        asm_d[0]   = in_data;
                        cnt_d      = slot_t'(1);
                        sync_err_d = 1'b1;
                    end else begin
                        asm_d[cnt_q] = in_data;
                        if (cnt_q == LAST_SLOT) begin
                            cnt_d = '0;
                            if (!out_valid_q || out_ready) begin
                                out_d       = asm_d;
                                out_valid_d = 1'b1;
                                state_d     = HUNT;
                            end else begin
                                state_d = STALL;
                            end
                        end else begin
                            cnt_d = cnt_q + slot_t'(1);
                        end
                    end
                end
            end

            STALL: begin
                if (take) begin
                    out_d       = asm_q;
                    out_valid_d = 1'b1;
                    state_d     = HUNT;
                end
            end

            default: begin
                state_d = HUNT;
            end
        endcase
    end

    // State, counter, assembly and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            cnt_q       <= '0;
            asm_q       <= '{default: '0};
            out_q       <= '{default: '0};
            out_valid_q <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            asm_q       <= asm_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            sync_err_q  <= sync_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign sync_err  = sync_err_q;
    assign out_ch0   = out_q[0];
    assign out_ch1   = out_q[1];
    assign out_ch2   = out_q[2];
    assign out_ch3   = out_q[3];

endmodule

// File: tb/tb_tdm_demux_4ch.sv
// Scoreboard bench for tdm_demux_4ch: frame-level reference model plus directed
// and randomized beat streams.
module tb_tdm_demux_4ch;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_sof = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         out_ready = 1'b0;
    logic         in_ready;
    logic         out_valid;
    logic         sync_err;
    logic [W-1:0] out_ch0, out_ch1, out_ch2, out_ch3;

    tdm_demux_4ch #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_sof   (in_sof),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_ch0  (out_ch0),
        .out_ch1  (out_ch1),
        .out_ch2  (out_ch2),
        .out_ch3  (out_ch3),
        .sync_err (sync_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Reference model state: completed frames not yet taken, partial frame.
    logic [4*W-1:0] exp_q [$];
    logic [4*W-1:0] part = '0;
    int             part_n = 0;
    bit             exp_sync = 1'b0;
    int             frames_in = 0;
    int             frames_out = 0;
    int             sync_seen = 0;
    bit             rand_rdy = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor + model: outputs are sampled mid-cycle; the model then absorbs this cycle's handshakes.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            part_n   = 0;
            exp_sync = 1'b0;
        end else begin
            bit er;
            bit acc;
            er = (exp_q.size() < 2);
            check("in_ready", 64'(in_ready), 64'(er));
            check("out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
            check("sync_err", 64'(sync_err), 64'(exp_sync));
            if (sync_err) sync_seen++;
            exp_sync = 1'b0;

            if (exp_q.size() > 0) begin
                check("out_frame", 64'({out_ch3, out_ch2, out_ch1, out_ch0}), 64'(exp_q[0]));
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    frames_out++;
                end
            end

            acc = in_valid && er;
            if (acc) begin
                if (in_sof) begin
                    if (part_n > 0) exp_sync = 1'b1;
                    part          = '0;
                    part[W-1:0]   = in_data;
                    part_n        = 1;
                end else if (part_n > 0) begin
                    part[part_n*W +: W] = in_data;
                    part_n++;
                    if (part_n == 4) begin
                        exp_q.push_back(part);
                        frames_in++;
                        part_n = 0;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    endtask

    // Present one beat and hold it until accepted (bounded).
    task automatic send_beat(input bit sof, input logic [W-1:0] data);
        bit got;
        got      = 1'b0;
        in_valid = 1'b1;
        in_sof   = sof;
        in_data  = data;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            got = in_ready;
            tick();
            if (got) break;
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL beat_timeout: got stalled expected accepted data=%0h", data);
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic send_frame(input logic [W-1:0] d0, input logic [W-1:0] d1,
                              input logic [W-1:0] d2, input logic [W-1:0] d3);
        send_beat(1'b1, d0);
        send_beat(1'b0, d1);
        send_beat(1'b0, d2);
        send_beat(1'b0, d3);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        check({tag, "_sync_err"}, 64'(sync_err), 64'd0);
        check({tag, "_out_ch"}, 64'({out_ch3, out_ch2, out_ch1, out_ch0}), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int sync_before;

        repeat (2) tick();
        check_reset_values("reset");
        rst_n = 1'b1;
        tick();

        // Basic frame with latency and content checked by the model.
        out_ready = 1'b1;
        send_frame(8'hA1, 8'hB2, 8'hC3, 8'hD4);
        repeat (2) tick();

        // Beats before any sof are dropped.
        send_beat(1'b0, 8'h55);
        send_beat(1'b0, 8'h55);
        send_beat(1'b0, 8'h55);
        send_frame(8'h10, 8'h11, 8'h12, 8'h13);
        repeat (2) tick();

        // Mid-frame sof restarts the frame and pulses sync_err once.
        sync_before = sync_seen;
        send_beat(1'b1, 8'h01);
        send_beat(1'b0, 8'h02);
        send_frame(8'h20, 8'h21, 8'h22, 8'h23);
        repeat (2) tick();
        check("sync_err_pulses", 64'(sync_seen - sync_before), 64'd1);

        // Backpressure: two frames buffered, then a stalled beat, then release.
        out_ready = 1'b0;
        send_frame(8'h14, 8'h15, 8'h16, 8'h17);
        send_frame(8'h24, 8'h25, 8'h26, 8'h27);
        in_valid = 1'b1;
        in_sof   = 1'b1;
        in_data  = 8'h30;
        repeat (3) tick();
        check("stall_in_ready", 64'(in_ready), 64'd0);
        check("held_frame", 64'({out_ch3, out_ch2, out_ch1, out_ch0}), 64'h17161514);
        out_ready = 1'b1;
        send_beat(1'b1, 8'h30);
        send_beat(1'b0, 8'h31);
        send_beat(1'b0, 8'h32);
        send_beat(1'b0, 8'h33);
        repeat (2) tick();

        // Sustained back-to-back frames at one frame per four cycles.
        for (int f = 0; f < 5; f++) begin
            send_frame(8'(8'h40 + 4*f), 8'(8'h41 + 4*f), 8'(8'h42 + 4*f), 8'(8'h43 + 4*f));
        end
        repeat (2) tick();

        // Reset after slot 2 of a frame clears everything immediately.
        send_beat(1'b1, 8'h60);
        send_beat(1'b0, 8'h61);
        send_beat(1'b0, 8'h62);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("midreset");
        tick();
        rst_n = 1'b1;
        tick();
        send_frame(8'h70, 8'h71, 8'h72, 8'h73);
        repeat (2) tick();

        // Randomized stream: mostly well-formed frames, occasional stray sof, gaps, random ready.
        rand_rdy = 1'b1;
        for (int i = 0, pos = 0; i < 400; i++) begin
            bit sof;
            if ($urandom_range(0, 4) == 0) begin
                in_valid = 1'b0;
                in_sof   = 1'($urandom_range(0, 1));
                tick();
                in_sof   = 1'b0;
            end
            sof = (pos == 0);
            if ($urandom_range(0, 19) == 0) sof = ~sof;
            send_beat(sof, 8'($urandom));
            pos = sof ? 1 : (pos + 1) % 4;
        end

        // Drain and confirm every completed frame was delivered.
        rand_rdy  = 1'b0;
        out_ready = 1'b1;
        repeat (6) tick();
        check("drained", 64'(exp_q.size()), 64'd0);
        check("frame_count", 64'(frames_out), 64'(frames_in));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
